// File: rtl/aes_result_display.sv
// Steps a captured 128-bit AES result across three seven-segment digits: byte index, high nibble, low nibble.
// Build option AES_DISP_WRAP_EN: loop the 16 bytes forever instead of holding the last one in DONE.
module aes_result_display #(
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] result,
  input  logic         result_valid,
  output logic [20:0]  sevenSeg,
  output logic         busy,
  output logic         done
);

  localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [6:0]  SEG_DASH = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           valid_q;
  logic [3:0]     idx_q, idx_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic [127:0]   data_q, data_d;
  logic           rise;
  logic [7:0]     cur_byte;

  assign rise = result_valid & ~valid_q;

  // Active-low hex glyphs, segment order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      idx_q   <= 4'd0;
      dwell_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= result_valid;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      data_q  <= data_d;
    end
  end

  // A capture outranks a dwell expiry on the same edge
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    data_d  = data_q;
    if (rise) begin
      data_d  = result;
      idx_d   = 4'd0;
      dwell_d = '0;
      state_d = SHOW;
    end else if (state_q == SHOW) begin
      if (dwell_q == DW'(DWELL_CYCLES - 1)) begin
        dwell_d = '0;
        if (idx_q == 4'd15) begin
`ifdef AES_DISP_WRAP_EN
          idx_d   = 4'd0;
`else
          state_d = DONE;
`endif
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end
  end

  // Byte k lives at bits 127-8k down; that MSB index is {~k, 3'b111}
  assign cur_byte = data_q[{~idx_q, 3'b111} -: 8];

  assign sevenSeg = (state_q == IDLE) ? {SEG_DASH, SEG_DASH, SEG_DASH}
                                      : {hex7(idx_q), hex7(cur_byte[7:4]), hex7(cur_byte[3:0])};
  assign busy     = (state_q == SHOW);
`ifdef AES_DISP_WRAP_EN
  assign done     = 1'b0;
`else
  assign done     = (state_q == DONE);
`endif

endmodule

// File: doc/aes_result_display.md
# aes_result_display

Downstream display sequencer for the AES demo top level. Captures the 128-bit result word when the core's completion flag rises, then steps through its 16 bytes on the board's three seven-segment digits. Each byte is shown for a fixed dwell time, as byte index followed by byte value in hex. Output format matches the 21-bit `sevenSeg` bus already driven at top level.

## Interface

Parameters:
- `DWELL_CYCLES`, default 50_000_000: clock cycles each byte stays on display; legal range ≥ 1.

Ports:
- `clk`  input  1  system clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `result`  input  128  AES output word; sampled only on the capture cycle.
- `result_valid`  input  1  AES completion flag (level); its 0→1 transition triggers capture.
- `sevenSeg`  output  21  three active-low digits, `{g,f,e,d,c,b,a}` per digit:
  - [20:14] byte index
  - [13:7] high nibble
  - [6:0] low nibble
- `busy`  output  1  high while bytes are being sequenced.
- `done`  output  1  high once the last byte has completed its dwell (non-wrap build only).

## Operation

- **Edge detect.** `valid_q` registers `result_valid`. Rise = `result_valid & ~valid_q`.
- **States.**
  - IDLE (reset state): all digits show dash, `7'b0111111`.
  - SHOW: bytes are sequenced.
  - DONE: last byte is held on display.
- **Capture.** A rise in any state loads `result` into `data_q` and sets `idx=0`, `dwell=0`, state=SHOW. A rise mid-sequence restarts from byte 0 with the new data.
- **Byte order.** Byte k = `data_q[127-8k -: 8]`, so byte 0 is the MSB byte.
- **Dwell counter.** Width `$clog2(DWELL_CYCLES)`, minimum 1 bit.
  - In SHOW, `dwell` increments every cycle.
  - At `dwell==DWELL_CYCLES-1`, `dwell` clears and `idx` advances.
  - `DWELL_CYCLES==1` advances every cycle.
- **End of sequence.** When `idx==15` and the dwell expires, the next state depends on the build (see Configuration).
- **Hex decode.** Active-low codes, 0–F:
  - 0 `1000000`, 1 `1111001`, 2 `0100100`, 3 `0110000`
  - 4 `0011001`, 5 `0010010`, 6 `0000010`, 7 `1111000`
  - 8 `0000000`, 9 `0010000`, A `0001000`, b `0000011`
  - C `1000110`, d `0100001`, E `0000110`, F `0001110`
- **Outputs.** `busy` = (state==SHOW). `done` = (state==DONE).

## Timing

- **Reset.** Asynchronous and immediate, including mid-sequence. Reset values:
  - state=IDLE, `valid_q=0`, `idx=0`, `dwell=0`, `data_q=0`
  - `sevenSeg=21'h0FDFBF` (three dashes), `busy=0`, `done=0`
- **Capture latency.** Rise sampled at edge N. After edge N, `sevenSeg` shows byte 0 and `busy=1`.
- **Output decode.** `sevenSeg`, `busy` and `done` are pure combinational decodes of registered state. They have no extra pipeline stage.
- **Byte timing.** Byte k is visible from edge N+k·DWELL_CYCLES through edge N+(k+1)·DWELL_CYCLES−1.
- **Level behaviour of `result_valid`.**
  - Held high: only one capture.
  - Must return low for ≥1 sampled cycle before the next capture.
- **Rise on the advance edge.** A rise on the same edge as a dwell expiry wins: capture and restart, with no advance.
- **`result` stability.** `result` is not required to stay stable after the capture edge.

## Configuration

Macro `AES_DISP_WRAP_EN`:
- **Defined.** After byte 15's dwell, `idx` wraps to 0 and state stays SHOW. The display loops indefinitely. DONE is unreachable and `done` is tied 0.
- **Undefined.** After byte 15's dwell, state goes to DONE. In DONE:
  - byte 15 stays displayed;
  - `busy=0`, `done=1`;
  - the dwell counter is frozen until the next rise or reset.

## Test plan

All scenarios use `DWELL_CYCLES=4` and `result=128'h69c4e0d86a7b0430d8cdb78070b4c55a`.

- **Reset.** Assert `reset=0` mid-run → `sevenSeg=21'h0FDFBF`, `busy=0`, `done=0` immediately, with no clock edge needed.
- **Capture.** Raise `result_valid` → next cycle `sevenSeg={1000000,0000010,0010000}` ("0 6 9") and `busy=1`. Four cycles later it shows "1 C 4" = `{1111001,1000110,0011001}`.
- **Non-wrap end.** After 64 cycles → "F 5 A" = `{0001110,0010010,0001000}` held, `done=1`, `busy=0`. It persists for 100 further cycles.
- **Wrap build.** With `AES_DISP_WRAP_EN` defined, at cycle 64 the display returns to "0 6 9" and `done` stays 0.
- **Restart.** New rise during byte 7 with `result=128'hFF00…00` → byte 0 shows "0 F F" = `{1000000,0001110,0001110}`.
- **Held valid.** Hold `result_valid` high for 200 cycles → exactly one capture, with no restart at cycle 100.
